// File: rtl/rcc_rtc_clk_ratio_mon.sv
// RTC divided-clock ratio monitor: measures the period of div_clk_in in i_clk cycles
// and reports the recovered ratio, lock, stopped-clock and ratio-mismatch status.
module rcc_rtc_clk_ratio_mon #(
    parameter int RATIO_WID = 6,
    parameter int LOCK_CNT  = 3
) (
    input  logic                 i_clk,
    input  logic                 rst_n,
    input  logic                 div_clk_in,
    input  logic [RATIO_WID-1:0] exp_ratio,
    output logic [RATIO_WID-1:0] meas_ratio,
    output logic                 meas_valid,
    output logic                 locked,
    output logic                 stopped,
    output logic                 ratio_err
);

    localparam logic [1:0] ST_SEEK = 2'd0;
    localparam logic [1:0] ST_MEAS = 2'd1;
    localparam logic [1:0] ST_LOCK = 2'd2;

    localparam logic [RATIO_WID:0] CNT_MAX   = {1'b1, {RATIO_WID{1'b0}}};
    localparam logic [RATIO_WID:0] CNT_ONE   = {{RATIO_WID{1'b0}}, 1'b1};
    localparam logic [3:0]         MATCH_MAX = 4'(LOCK_CNT);

    logic                 sync1_q, sync2_q, hist_q;
    logic [1:0]           state_q, state_d;
    logic [RATIO_WID:0]   cnt_q, cnt_d;
    logic [3:0]           match_q, match_d;
    logic [RATIO_WID-1:0] meas_ratio_q, meas_ratio_d;
    logic                 meas_valid_q, meas_valid_d;
    logic                 locked_q, locked_d;
    logic                 stopped_q, stopped_d;
    logic                 ratio_err_q, ratio_err_d;

    logic                 rise;
    logic                 timeout;
    logic [RATIO_WID-1:0] period;

    assign rise    = sync2_q & ~hist_q;
    assign period  = cnt_q[RATIO_WID-1:0];
    // A rise coinciding with saturation is discarded: the period is out of range.
    assign timeout = (state_q != ST_SEEK) && (cnt_q == CNT_MAX);

    always_comb begin
        state_d      = state_q;
        match_d      = match_q;
        meas_ratio_d = meas_ratio_q;
        meas_valid_d = 1'b0;
        locked_d     = locked_q;
        stopped_d    = stopped_q;
        ratio_err_d  = locked_q && (meas_ratio_q != exp_ratio);
        if (state_q == ST_SEEK) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end

        if (timeout) begin
            state_d   = ST_SEEK;
            stopped_d = 1'b1;
            locked_d  = 1'b0;
            match_d   = '0;
            cnt_d     = '0;
        end else begin
            case (state_q)
                ST_SEEK: begin
                    if (rise) begin
                        state_d   = ST_MEAS;
                        stopped_d = 1'b0;
                        cnt_d     = CNT_ONE;
                    end
                end
                ST_MEAS: begin
                    if (rise) begin
                        cnt_d        = CNT_ONE;
                        meas_ratio_d = period;
                        meas_valid_d = 1'b1;
                        if (period == meas_ratio_q) begin
                            match_d = (match_q < MATCH_MAX) ? match_q + 4'd1 : match_q;
                        end else begin
                            match_d = 4'd1;
                        end
                        if (match_d == MATCH_MAX) begin
                            locked_d = 1'b1;
                            state_d  = ST_LOCK;
                        end
                    end
                end
                ST_LOCK: begin
                    if (rise) begin
                        cnt_d        = CNT_ONE;
                        meas_valid_d = 1'b1;
                        if (period != meas_ratio_q) begin
                            locked_d     = 1'b0;
                            match_d      = 4'd1;
                            meas_ratio_d = period;
                            state_d      = ST_MEAS;
                        end
                    end
                end
                default: state_d = ST_SEEK;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            hist_q       <= 1'b0;
            state_q      <= ST_SEEK;
            cnt_q        <= '0;
            match_q      <= '0;
            meas_ratio_q <= '0;
            meas_valid_q <= 1'b0;
            locked_q     <= 1'b0;
            stopped_q    <= 1'b0;
            ratio_err_q  <= 1'b0;
        end else begin
            sync1_q      <= div_clk_in;
            sync2_q      <= sync1_q;
            hist_q       <= sync2_q;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            match_q      <= match_d;
            meas_ratio_q <= meas_ratio_d;
            meas_valid_q <= meas_valid_d;
            locked_q     <= locked_d;
            stopped_q    <= stopped_d;
            ratio_err_q  <= ratio_err_d;
        end
    end

    assign meas_ratio = meas_ratio_q;
    assign meas_valid = meas_valid_q;
    assign locked     = locked_q;
    assign stopped    = stopped_q;
    assign ratio_err  = ratio_err_q;

endmodule

// File: doc/rcc_rtc_clk_ratio_mon.md
Name: rcc_rtc_clk_ratio_mon

Overview:
- Receive-side checker for the RTC divided clock: samples a divided clock in the source clock domain, measures its period in i_clk cycles, and reports the recovered ratio, lock status, stopped-clock status and mismatch against the programmed ratio.
- Sits beside the RTC divider in the RCC. Its output feeds status registers and a safety/interrupt path.

Parameters:
- RATIO_WID, 6, width of the ratio fields. The measurable period range is 2 to 2^RATIO_WID-1 cycles.
- LOCK_CNT, 3, number of consecutive identical measurements required to assert locked (range 1..15).

Ports:
- i_clk  input  1  source clock; the same clock that drives the divider.
- rst_n  input  1  reset; asynchronous, active-low.
- div_clk_in  input  1  divided clock under observation; treated as asynchronous.
- exp_ratio  input  RATIO_WID  programmed ratio; quasi-static; compared only while locked.
- meas_ratio  output  RATIO_WID  last measured period in i_clk cycles.
- meas_valid  output  1  one-cycle pulse when meas_ratio updates.
- locked  output  1  period stable for LOCK_CNT consecutive measurements.
- stopped  output  1  no rising edge seen for 2^RATIO_WID cycles.
- ratio_err  output  1  locked && (meas_ratio != exp_ratio).

Behaviour:
- Reset (async assert, release on i_clk): all outputs 0; synchronizers 0; state SEEK; period counter 0; match counter 0.
- Input path:
  - div_clk_in passes through a 2-flop synchronizer plus one history flop.
  - rise = sync_q & ~hist_q.
  - Edge-to-detect latency is 3 i_clk cycles. It is constant, so measured periods are unaffected.
- Period counter:
  - Width RATIO_WID+1.
  - Loaded to 1 in the cycle after a rise; increments each cycle otherwise.
  - Saturates at 2^RATIO_WID.
  - On a rise, the captured period P equals the counter value, so periodic edges every P cycles capture P.
- States:
  - SEEK: wait for the first rise. On rise, start the counter and go to MEAS. No measurement is produced.
  - MEAS: on rise with counter < 2^RATIO_WID:
    - meas_ratio <= P[RATIO_WID-1:0] and meas_valid pulses in the cycle after the rise.
    - If P == previous P, the match counter increments (saturating at LOCK_CNT); otherwise it is set to 1.
    - When the match counter reaches LOCK_CNT, go to LOCK and assert locked in the same cycle as that meas_valid.
  - LOCK: on rise with P == meas_ratio, stay in LOCK. On rise with a different P, deassert locked, set match counter to 1, update meas_ratio with meas_valid, and go to MEAS.
  - Any state except SEEK: when the counter reaches 2^RATIO_WID, assert stopped, deassert locked, clear match counter, go to SEEK. meas_ratio holds its last value.
- stopped clears on the first rise after it was set. That rise does not produce a measurement, because it re-enters via SEEK.
- Out-of-range periods:
  - Ratio bypass (div_clk_in == i_clk or constant) shows no edges in the sampled domain and produces stopped.
  - A period of 1 is unobservable and is treated the same way.
- LOCK_CNT = 1: locked asserts on the first valid measurement.
- ratio_err:
  - Registered.
  - Evaluated each cycle as locked && meas_ratio != exp_ratio.
  - Goes 0 when locked drops.
  - An exp_ratio change while locked is reflected one cycle later.
- A rise in the same cycle the counter reaches 2^RATIO_WID is treated as timeout; timeout wins.
- Reset mid-operation: immediate return to reset values. The first measurement after release needs two observed rises.

Test Plan:
- Period 4 steady, exp_ratio=4, LOCK_CNT=3:
  - meas_valid every 4 cycles with meas_ratio=4.
  - locked rises with the 3rd meas_valid.
  - ratio_err stays 0.
- Locked at 4, then switch to period 6:
  - First 6 measurement drops locked and sets meas_ratio=6.
  - locked re-asserts at the 3rd consecutive 6.
  - ratio_err is 1 after relock while exp_ratio is still 4, and clears one cycle after exp_ratio=6.
- Hold div_clk_in low while locked at period 8:
  - stopped=1 and locked=0 exactly 64 cycles (RATIO_WID=6) after the counter restart.
  - Restart the clock: stopped clears on the first rise, meas_valid first on the second rise.
- Boundary periods:
  - Period 2 measures 2 and locks.
  - Period 63 measures 63 and locks.
  - Period ≥64 never produces meas_valid; stopped toggles instead.
- Jitter pattern 5,5,6,5,5,5: locked only after the final three 5s; match counter resets on the 6.
- Assert rst_n low mid-LOCK: all outputs 0 asynchronously; after release, no meas_valid before the second rise.
